// File: rtl/mem_access_pkg.sv
// Shared encodings for the load/store stage: funct3 access sizes, FSM states
// and the default bus timeout.
package mem_access_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int TIMEOUT_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Undefined size encodings fault, as do halfwords/words off their natural boundary.
    function automatic logic access_fault(input logic [2:0] f3, input logic [1:0] lo);
        logic flt;
        case (f3)
            F3_B, F3_BU: flt = 1'b0;
            F3_H, F3_HU: flt = lo[0];
            F3_W:        flt = (lo != 2'b00);
            default:     flt = 1'b1;
        endcase
        return flt;
    endfunction

endpackage

// File: rtl/mem_access_load_align.sv
// Selects the addressed byte/halfword from a read word and sign- or
// zero-extends it according to funct3.
module load_align
    import mem_access_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane extraction followed by extension.
    always_comb begin
        byte_s = rdata[8*off +: 8];
        half_s = rdata[16*off[1] +: 16];
        case (funct3)
            F3_B:    result = {{24{byte_s[7]}}, byte_s};
            F3_H:    result = {{16{half_s[15]}}, half_s};
            F3_W:    result = rdata;
            F3_BU:   result = {24'h000000, byte_s};
            F3_HU:   result = {16'h0000, half_s};
            default: result = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Load/store stage: issues one req/ack data-memory access per instruction,
// stalls the core while it is in flight and produces the writeback value.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [2:0]  funct3,
    input  logic [31:0] alu_out,
    input  logic [31:0] rs2_data,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic [31:0] mem_out,
    output logic        done,
    output logic        stall,
    output logic        misalign,
    output logic        bus_err
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT - 1);

    state_t      state, state_nx;
    logic [CW-1:0] cnt;
    logic [1:0]  off_r;
    logic [2:0]  f3_r;
    logic        ld_r;
    logic [31:0] mem_out_r;
    logic        is_mem, pass, fault;
    logic [3:0]  be_s;
    logic [31:0] wdata_s;
    logic [31:0] ld_val;

    load_align u_align (
        .rdata  (dmem_rdata),
        .off    (off_r),
        .funct3 (f3_r),
        .result (ld_val)
    );

    // Decode of the incoming instruction: lane enables, replicated store data, fault.
    always_comb begin
        is_mem = mem_rd | mem_wr;
        pass   = (state == IDLE) & valid & ~is_mem;
        fault  = access_fault(funct3, alu_out[1:0]);
        case (funct3[1:0])
            2'b00: begin
                be_s    = 4'b0001 << alu_out[1:0];
                wdata_s = {4{rs2_data[7:0]}};
            end
            2'b01: begin
                be_s    = 4'b0011 << alu_out[1:0];
                wdata_s = {2{rs2_data[15:0]}};
            end
            2'b10: begin
                be_s    = 4'b1111;
                wdata_s = rs2_data;
            end
            default: begin
                be_s    = 4'b0000;
                wdata_s = 32'h0000_0000;
            end
        endcase
    end

    // Next-state selection.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (valid && is_mem) begin
                    state_nx = fault ? DONE : REQ;
                end else begin
                    state_nx = IDLE;
                end
            end
            REQ: begin
                if (dmem_ack || (cnt == TMAX)) begin
                    state_nx = DONE;
                end else begin
                    state_nx = REQ;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State register plus the bus and result registers it sequences.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= 32'h0000_0000;
            dmem_be    <= 4'b0000;
            dmem_wdata <= 32'h0000_0000;
            off_r      <= 2'b00;
            f3_r       <= 3'b000;
            ld_r       <= 1'b0;
            mem_out_r  <= 32'h0000_0000;
            misalign   <= 1'b0;
            bus_err    <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (valid && is_mem) begin
                        mem_out_r <= 32'h0000_0000;
                        cnt       <= '0;
                        if (fault) begin
                            misalign <= 1'b1;
                        end else begin
                            dmem_req   <= 1'b1;
                            dmem_we    <= mem_wr & ~mem_rd;
                            dmem_addr  <= {alu_out[31:2], 2'b00};
                            dmem_be    <= be_s;
                            dmem_wdata <= wdata_s;
                            off_r      <= alu_out[1:0];
                            f3_r       <= funct3;
                            ld_r       <= mem_rd;
                        end
                    end
                end
                REQ: begin
                    // An ack in the final timeout cycle still completes normally.
                    if (dmem_ack) begin
                        dmem_req  <= 1'b0;
                        dmem_we   <= 1'b0;
                        mem_out_r <= ld_r ? ld_val : 32'h0000_0000;
                    end else if (cnt == TMAX) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        bus_err  <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    misalign  <= 1'b0;
                    bus_err   <= 1'b0;
                    mem_out_r <= 32'h0000_0000;
                end
                default: begin
                    misalign <= 1'b0;
                    bus_err  <= 1'b0;
                end
            endcase
        end
    end

    // Completion and stall; non-memory instructions bypass the registers.
    always_comb begin
        mem_out = mem_out_r;
        done    = (state == DONE);
        stall   = valid & is_mem & (state != DONE);
        if (pass) begin
            mem_out = alu_out;
            done    = 1'b1;
        end else begin
            mem_out = mem_out_r;
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed table, randomized ops against
// a behavioural model, and reset during an outstanding access.
module tb_mem_access;
    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        reset, valid, mem_rd, mem_wr, dmem_ack;
    logic [2:0]  funct3;
    logic [31:0] alu_out, rs2_data, dmem_rdata;
    logic        dmem_req, dmem_we, done, stall, misalign, bus_err;
    logic [31:0] dmem_addr, dmem_wdata, mem_out;
    logic [3:0]  dmem_be;
    logic [31:0] la_rd, la_res;
    logic [1:0]  la_off;
    logic [2:0]  la_f3;

    int total = 0;
    int bad   = 0;

    mem_access #(.TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .valid(valid), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .funct3(funct3), .alu_out(alu_out), .rs2_data(rs2_data),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .mem_out(mem_out), .done(done), .stall(stall), .misalign(misalign), .bus_err(bus_err)
    );

    load_align la (.rdata(la_rd), .off(la_off), .funct3(la_f3), .result(la_res));

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] out;
        logic        mis, berr, we;
        int          lat, reqs;
        logic [3:0]  be;
        logic [31:0] wdata;
    } exp_t;

    typedef struct {
        logic [31:0] out, addr, wdata;
        logic        mis, berr, we, stall_ok, stable, done_after, got_done;
        logic [3:0]  be;
        int          lat, reqs;
    } obs_t;

    typedef struct {
        logic        rd, wr;
        logic [2:0]  f3;
        logic [31:0] a, d, rdat;
        int          ack_at;
        exp_t        e;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: access size in bytes, alignment by modulo, extension by masking.
    function automatic exp_t model(input logic rd, input logic wr, input logic [2:0] f3,
                                   input logic [31:0] a, input logic [31:0] d,
                                   input logic [31:0] rdat, input int ack_at);
        exp_t e;
        int size, off;
        logic [31:0] v, mask;
        bit flt, tmo;
        e = '{out: 32'd0, mis: 1'b0, berr: 1'b0, we: 1'b0, lat: 0, reqs: 0, be: 4'd0, wdata: 32'd0};
        off  = int'(a[1:0]);
        size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : (f3[1:0] == 2'd2) ? 4 : 0;
        if (size == 0 || f3 == 3'd6) flt = 1'b1;
        else flt = (off % size) != 0;
        if (!(rd || wr)) begin
            e.out = a; e.lat = 1;
            return e;
        end
        if (flt) begin
            e.mis = 1'b1; e.lat = 2;
            return e;
        end
        tmo    = (ack_at < 1) || (ack_at > TMO);
        e.reqs = tmo ? TMO : ack_at;
        e.lat  = e.reqs + 2;
        e.berr = tmo;
        e.we   = wr && !rd;
        e.be   = 4'(((1 << size) - 1) << off);
        for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = d[8*(i % size) +: 8];
        if (rd && !tmo) begin
            v    = rdat >> (8 * off);
            mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
            v    = v & mask;
            if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~mask;
            e.out = v;
        end
        return e;
    endfunction

    // Issue one instruction, act as the memory, observe until done (bounded).
    task automatic do_op(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d, input logic [31:0] rdat,
                         input int ack_at, output obs_t o);
        o = '{out: 32'd0, addr: 32'd0, wdata: 32'd0, mis: 1'b0, berr: 1'b0, we: 1'b0,
              stall_ok: 1'b1, stable: 1'b1, done_after: 1'b0, got_done: 1'b0, be: 4'd0,
              lat: 0, reqs: 0};
        @(negedge clk);
        valid = 1'b1; mem_rd = rd; mem_wr = wr; funct3 = f3;
        alu_out = a; rs2_data = d; dmem_ack = 1'b0;
        for (int c = 0; c < 64; c++) begin
            #1;
            if (done) begin
                o.got_done = 1'b1; o.lat = c + 1; o.out = mem_out;
                o.mis = misalign; o.berr = bus_err;
                if (stall !== 1'b0) o.stall_ok = 1'b0;
                break;
            end
            if (stall !== (rd | wr)) o.stall_ok = 1'b0;
            if (dmem_req) begin
                o.reqs++;
                if (o.reqs == 1) begin
                    o.addr = dmem_addr; o.be = dmem_be; o.wdata = dmem_wdata; o.we = dmem_we;
                end else if (dmem_addr !== o.addr || dmem_be !== o.be ||
                             dmem_wdata !== o.wdata || dmem_we !== o.we) begin
                    o.stable = 1'b0;
                end
                dmem_ack   = (o.reqs == ack_at);
                dmem_rdata = dmem_ack ? rdat : $urandom;
            end
            @(negedge clk);
            dmem_ack = 1'b0;
        end
        @(negedge clk);
        valid = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0; dmem_ack = 1'b0;
        #1;
        o.done_after = done;
    endtask

    task automatic compare(input string tag, input exp_t e, input obs_t o, input logic [31:0] a);
        chk({tag, ".done_seen"}, 32'(o.got_done), 32'd1);
        chk({tag, ".mem_out"}, o.out, e.out);
        chk({tag, ".misalign"}, 32'(o.mis), 32'(e.mis));
        chk({tag, ".bus_err"}, 32'(o.berr), 32'(e.berr));
        chk({tag, ".latency"}, 32'(o.lat), 32'(e.lat));
        chk({tag, ".req_cycles"}, 32'(o.reqs), 32'(e.reqs));
        chk({tag, ".stall"}, 32'(o.stall_ok), 32'd1);
        chk({tag, ".done_one_cycle"}, 32'(o.done_after), 32'd0);
        if (e.reqs > 0) begin
            chk({tag, ".addr"}, o.addr, {a[31:2], 2'b00});
            chk({tag, ".be"}, 32'(o.be), 32'(e.be));
            chk({tag, ".wdata"}, o.wdata, e.wdata);
            chk({tag, ".we"}, 32'(o.we), 32'(e.we));
            chk({tag, ".held"}, 32'(o.stable), 32'd1);
        end
    endtask

    vec_t vecs[12];
    obs_t ob;
    exp_t ex;

    initial begin
        // rd wr f3 addr data rdata ack_at | out mis berr we lat reqs be wdata
        vecs[0]  = '{1'b0, 1'b0, 3'b000, 32'h1234_5678, 32'h0, 32'h0, 0,
                     '{32'h1234_5678, 1'b0, 1'b0, 1'b0, 1, 0, 4'b0000, 32'h0}};
        vecs[1]  = '{1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'h0, 32'h8000_0000, 3,
                     '{32'hFFFF_FF80, 1'b0, 1'b0, 1'b0, 5, 3, 4'b1000, 32'h0}};
        vecs[2]  = '{1'b1, 1'b0, 3'b101, 32'h0000_2002, 32'h0, 32'hBEEF_0000, 1,
                     '{32'h0000_BEEF, 1'b0, 1'b0, 1'b0, 3, 1, 4'b1100, 32'h0}};
        vecs[3]  = '{1'b0, 1'b1, 3'b001, 32'h0000_2002, 32'h1111_ABCD, 32'h0, 2,
                     '{32'h0, 1'b0, 1'b0, 1'b1, 4, 2, 4'b1100, 32'hABCD_ABCD}};
        vecs[4]  = '{1'b1, 1'b0, 3'b010, 32'h0000_0006, 32'h0, 32'h0, 1,
                     '{32'h0, 1'b1, 1'b0, 1'b0, 2, 0, 4'b0000, 32'h0}};
        vecs[5]  = '{1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 32'h0, 0,
                     '{32'h0, 1'b0, 1'b1, 1'b0, 18, 16, 4'b1111, 32'h0}};
        vecs[6]  = '{1'b1, 1'b0, 3'b010, 32'h0000_0040, 32'h0, 32'hCAFE_F00D, 16,
                     '{32'hCAFE_F00D, 1'b0, 1'b0, 1'b0, 18, 16, 4'b1111, 32'h0}};
        vecs[7]  = '{1'b0, 1'b1, 3'b011, 32'h0000_0000, 32'h5, 32'h0, 1,
                     '{32'h0, 1'b1, 1'b0, 1'b0, 2, 0, 4'b0000, 32'h0}};
        vecs[8]  = '{1'b1, 1'b0, 3'b001, 32'h0000_0012, 32'h0, 32'h8001_7FFF, 1,
                     '{32'hFFFF_8001, 1'b0, 1'b0, 1'b0, 3, 1, 4'b1100, 32'h0}};
        vecs[9]  = '{1'b1, 1'b1, 3'b000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_7F00, 2,
                     '{32'h0000_007F, 1'b0, 1'b0, 1'b0, 4, 2, 4'b0010, 32'hFFFF_FFFF}};
        vecs[10] = '{1'b0, 1'b1, 3'b000, 32'h0000_0033, 32'h0000_AA55, 32'h0, 1,
                     '{32'h0, 1'b0, 1'b0, 1'b1, 3, 1, 4'b1000, 32'h5555_5555}};
        vecs[11] = '{1'b1, 1'b0, 3'b101, 32'h0000_0001, 32'h0, 32'h0, 1,
                     '{32'h0, 1'b1, 1'b0, 1'b0, 2, 0, 4'b0000, 32'h0}};

        reset = 1'b1; valid = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0; funct3 = 3'b000;
        alu_out = 32'h0; rs2_data = 32'h0; dmem_rdata = 32'h0; dmem_ack = 1'b0;
        la_rd = 32'h0; la_off = 2'b00; la_f3 = 3'b000;
        repeat (3) @(negedge clk);
        #1;
        chk("reset.req", 32'(dmem_req), 32'd0);
        chk("reset.done", 32'(done), 32'd0);
        chk("reset.flags", {30'd0, misalign, bus_err}, 32'd0);
        chk("reset.be_we", {27'd0, dmem_we, dmem_be}, 32'd0);
        chk("reset.addr", dmem_addr, 32'd0);
        chk("reset.wdata", dmem_wdata, 32'd0);
        chk("reset.mem_out", mem_out, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            do_op(vecs[i].rd, vecs[i].wr, vecs[i].f3, vecs[i].a, vecs[i].d, vecs[i].rdat,
                  vecs[i].ack_at, ob);
            compare($sformatf("vec%0d", i), vecs[i].e, ob, vecs[i].a);
        end

        for (int i = 0; i < 40; i++) begin
            logic rd, wr;
            logic [2:0] f3;
            logic [31:0] a, d, rdat;
            int ack_at;
            rd = 1'($urandom); wr = 1'($urandom); f3 = 3'($urandom);
            a = $urandom; d = $urandom; rdat = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = (f3[1:0] == 2'd2) ? 2'b00 : {a[1], 1'b0};
            ack_at = ($urandom_range(0, 19) == 0) ? 0 : int'($urandom_range(1, 5));
            ex = model(rd, wr, f3, a, d, rdat, ack_at);
            do_op(rd, wr, f3, a, d, rdat, ack_at, ob);
            compare($sformatf("rnd%0d", i), ex, ob, a);
        end

        for (int i = 0; i < 16; i++) begin
            logic [2:0] f3s[5];
            f3s = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
            la_f3 = f3s[$urandom_range(0, 4)];
            la_rd = $urandom;
            la_off = 2'($urandom);
            if (la_f3[1:0] == 2'b01) la_off[0] = 1'b0;
            if (la_f3[1:0] == 2'b10) la_off = 2'b00;
            #1;
            ex = model(1'b1, 1'b0, la_f3, {30'd0, la_off}, 32'd0, la_rd, 1);
            chk($sformatf("align%0d", i), la_res, ex.out);
        end

        // Reset while a load is outstanding; a stale ack afterwards must be ignored.
        begin
            int seen_req, dones;
            seen_req = 0; dones = 0;
            @(negedge clk);
            valid = 1'b1; mem_rd = 1'b1; funct3 = 3'b010; alu_out = 32'h0000_0080;
            for (int c = 0; c < 8 && seen_req == 0; c++) begin
                @(negedge clk);
                #1;
                if (dmem_req) seen_req = 1;
            end
            chk("rst_mid.req_seen", 32'(seen_req), 32'd1);
            repeat (2) @(negedge clk);
            reset = 1'b1; valid = 1'b0; mem_rd = 1'b0;
            @(negedge clk);
            #1;
            chk("rst_mid.req_drop", 32'(dmem_req), 32'd0);
            reset = 1'b0;
            @(negedge clk);
            dmem_ack = 1'b1; dmem_rdata = 32'h1357_9BDF;
            @(negedge clk);
            dmem_ack = 1'b0;
            for (int c = 0; c < 4; c++) begin
                #1;
                if (done) dones++;
                @(negedge clk);
            end
            chk("rst_mid.no_done", 32'(dones), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
